// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
//   - op encodings applied on the op input
//   - FSM state encoding
//   - default iteration count and iteration-counter width
package mult_div_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_ITER = 32;
  localparam int CNT_W        = 5;

endpackage

// File: rtl/div_step.sv
// One combinational step of unsigned restoring division.
// Ports:
//   rem          in   current partial remainder (always < divisor)
//   dividend_bit in   next dividend bit, shifted into the remainder LSB
//   divisor      in   divisor magnitude
//   rem_next     out  partial remainder after the trial subtraction
//   q_bit        out  quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted remainder can reach 2*divisor-1, which needs one extra bit
  // when the divisor magnitude is 2^(WIDTH-1).
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    q_bit    = (shifted >= {1'b0, divisor});
    // Only used when q_bit is set, in which case the true difference is
    // below the divisor and fits in WIDTH bits.
    diff     = shifted[WIDTH-1:0] - divisor;
    rem_next = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit (MIPS Hi/Lo semantics).
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   start    in   request pulse, sampled only in IDLE
//   op       in   0 = mult, 1 = div (sampled with start)
//   a, b     in   signed operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo   out  mult: product high/low; div: remainder/quotient
//   busy     out  operation in flight
//   done     out  one-cycle pulse, hi/lo valid in the same cycle
//   div_zero out  last div had b == 0; sticky until next accepted start
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = DEFAULT_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               op_reg;
  logic               sign_a_reg, sign_b_reg;
  // Multiplicand magnitude for mult, divisor magnitude for div.
  logic [WIDTH-1:0]   opnd_reg;
  // Mult: {partial product, remaining multiplier bits}.
  // Div:  {partial remainder, dividend bits shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               busy_reg, done_reg, div_zero_reg;

  // Magnitudes are unsigned, so 0x80000000 maps to 2^31 without overflow.
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_acc_next;
  logic [2*WIDTH-1:0] div_acc_next;
  logic [WIDTH-1:0]   div_rem_next;
  logic               div_q_bit;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed, rem_signed;
  logic               is_div_zero;

  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  // Shift-add multiply: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right.
  assign mult_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                       + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
  assign mult_acc_next = {mult_sum, acc_reg[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (acc_reg[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc_reg[WIDTH-1]),
    .divisor      (opnd_reg),
    .rem_next     (div_rem_next),
    .q_bit        (div_q_bit)
  );

  assign div_acc_next = {div_rem_next, acc_reg[WIDTH-2:0], div_q_bit};

  assign prod_signed = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quot_signed = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0]
                                                  : acc_reg[WIDTH-1:0];
  assign rem_signed  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                  : acc_reg[2*WIDTH-1:WIDTH];
  // A div reaching FIN with a zero divisor magnitude skipped RUN entirely.
  assign is_div_zero = (op_reg == OP_DIV) && (opnd_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ((op == OP_DIV) && (b == '0)) ? FIN : RUN;
        end
      end
      RUN: begin
        if (cnt_reg == CNT_W'(ITER - 1)) begin
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= OP_MULT;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg       <= op;
            sign_a_reg   <= a[WIDTH-1];
            sign_b_reg   <= b[WIDTH-1];
            busy_reg     <= 1'b1;
            div_zero_reg <= 1'b0;
            cnt_reg      <= '0;
            if (op == OP_DIV) begin
              opnd_reg <= mag_b;
              acc_reg  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd_reg <= mag_a;
              acc_reg  <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          acc_reg <= (op_reg == OP_DIV) ? div_acc_next : mult_acc_next;
        end
        FIN: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
          if (is_div_zero) begin
            div_zero_reg <= 1'b1;
          end else if (op_reg == OP_DIV) begin
            hi_reg <= rem_signed;
            lo_reg <= quot_signed;
          end else begin
            hi_reg <= prod_signed[2*WIDTH-1:WIDTH];
            lo_reg <= prod_signed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: hand-computed vectors for signed
// mult/div, divide-by-zero, overflow wrap, ignored start, mid-op reset and
// back-to-back issue.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after an edge; start is sampled at the next edge (E0),
  // returns 1 time unit after E0.
  task automatic launch(input logic o, input logic [31:0] va, input logic [31:0] vb);
    op    = o;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded). busy_cnt counts the busy
  // cycles after the call, excluding the done cycle.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic idle_watch(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
  endtask

  initial begin
    int cyc;
    int bcnt;
    int dcnt;

    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_dz", {31'b0, div_zero}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 7 * -3 = -21
    launch(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    wait_done(cyc, bcnt);
    $display("mult 7 x -3 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("m1_lat", cyc, 33);
    check("m1_hi", hi, 32'hFFFF_FFFF);
    check("m1_lo", lo, 32'hFFFF_FFEB);
    check("m1_dz", {31'b0, div_zero}, 32'h0);
    @(posedge clk);
    #1;
    check("m1_done_pulse", {31'b0, done}, 32'h0);

    // (-2^31) * (-2^31) = 2^62
    launch(1'b0, 32'h8000_0000, 32'h8000_0000);
    check("m2_busy0", {31'b0, busy}, 32'h1);
    wait_done(cyc, bcnt);
    $display("mult 80000000 x 80000000 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("m2_busy_len", bcnt + 1, 33);
    check("m2_hi", hi, 32'h4000_0000);
    check("m2_lo", lo, 32'h0000_0000);
    check("m2_busy_end", {31'b0, busy}, 32'h0);

    // -7 / 2 -> q=-3, r=-1
    launch(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(cyc, bcnt);
    $display("div -7 / 2 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("d1_lat", cyc, 33);
    check("d1_lo", lo, 32'hFFFF_FFFD);
    check("d1_hi", hi, 32'hFFFF_FFFF);

    // 7 / -2 -> q=-3, r=1
    launch(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done(cyc, bcnt);
    $display("div 7 / -2 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("d2_lo", lo, 32'hFFFF_FFFD);
    check("d2_hi", hi, 32'h0000_0001);

    // 0x451 / 0x20 -> q=0x22, r=0x11 (sets up hi/lo for the div-by-zero case)
    launch(1'b1, 32'h0000_0451, 32'h0000_0020);
    wait_done(cyc, bcnt);
    $display("div 451 / 20 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("d3_hi", hi, 32'h0000_0011);
    check("d3_lo", lo, 32'h0000_0022);

    // 5 / 0: fast done, hi/lo untouched, sticky flag
    launch(1'b1, 32'h0000_0005, 32'h0000_0000);
    wait_done(cyc, bcnt);
    $display("div 5 / 0 -> hi=%h lo=%h dz=%0d cycles=%0d", hi, lo, div_zero, cyc);
    check("dz_lat", cyc, 1);
    check("dz_flag", {31'b0, div_zero}, 32'h1);
    check("dz_hi", hi, 32'h0000_0011);
    check("dz_lo", lo, 32'h0000_0022);
    @(posedge clk);
    #1;
    check("dz_sticky", {31'b0, div_zero}, 32'h1);
    // next accepted start clears it: 2 * 3
    launch(1'b0, 32'h0000_0002, 32'h0000_0003);
    check("dz_clear", {31'b0, div_zero}, 32'h0);
    wait_done(cyc, bcnt);
    $display("mult 2 x 3 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("m3_lo", lo, 32'h0000_0006);

    // 0x80000000 / -1 wraps
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bcnt);
    $display("div 80000000 / -1 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("ov_lo", lo, 32'h8000_0000);
    check("ov_hi", hi, 32'h0000_0000);
    check("ov_dz", {31'b0, div_zero}, 32'h0);

    // start while busy is ignored; operand changes have no effect
    launch(1'b0, 32'h0000_0003, 32'h0000_0005);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    op    = 1'b1;
    a     = 32'h0000_0064;
    b     = 32'h0000_0064;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    $display("mult 3 x 5 (restart ignored) -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("ig_lat", cyc, 28);
    check("ig_hi", hi, 32'h0000_0000);
    check("ig_lo", lo, 32'h0000_000F);
    idle_watch(40, dcnt);
    check("ig_no_2nd_done", dcnt, 0);

    // reset at cycle 10 of an operation aborts it
    launch(1'b0, 32'h0000_0006, 32'h0000_0007);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    $display("reset mid mult -> busy=%0d hi=%h lo=%h", busy, hi, lo);
    check("ra_busy", {31'b0, busy}, 32'h0);
    check("ra_hi", hi, 32'h0);
    check("ra_lo", lo, 32'h0);
    check("ra_done", {31'b0, done}, 32'h0);
    reset = 1'b1;
    idle_watch(40, dcnt);
    check("ra_no_done", dcnt, 0);

    // back-to-back: start asserted in the done cycle is accepted
    launch(1'b0, 32'h0000_0009, 32'h0000_0009);
    wait_done(cyc, bcnt);
    $display("mult 9 x 9 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("bb1_lo", lo, 32'h0000_0051);
    launch(1'b1, 32'h0000_0064, 32'h0000_0007);
    check("bb2_busy", {31'b0, busy}, 32'h1);
    wait_done(cyc, bcnt);
    $display("div 100 / 7 -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    check("bb2_lat", cyc, 33);
    check("bb2_lo", lo, 32'h0000_000E);
    check("bb2_hi", hi, 32'h0000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS-subset CPU.
- Sits between the A/B operand registers and the Hi/Lo values consumed by the register-file write-data mux.
- The control unit pulses start with an op code, stalls on busy, and then samples hi/lo when done pulses.
- Produces MIPS-style results: mult gives a 64-bit product in hi:lo; div gives the quotient in lo and the remainder in hi.

Parameters:
- WIDTH, 32, operand and result-half width.
- ITER, 32, iterations per operation; equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset. Sampled only on the rising edge of clk; 0 = reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = mult, 1 = div; sampled together with start.
- a  in  WIDTH  multiplicand / dividend (signed, from A).
- b  in  WIDTH  multiplier / divisor (signed, from B).
- hi  out  WIDTH  mult: product[63:32]; div: remainder.
- lo  out  WIDTH  mult: product[31:0]; div: quotient.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi/lo are valid in this same cycle.
- div_zero  out  1  last div had b == 0; sticky until the next accepted start.

Behaviour:
- Reset (reset == 0 at an edge):
  - state = IDLE; hi = lo = 0; busy = done = div_zero = 0; iteration counter = 0.
  - Reset mid-operation aborts the operation with no done pulse.
- State machine: IDLE, RUN, FIN.
- IDLE, start == 1 at edge E0:
  - Latch op and the operand magnitudes/signs; clear div_zero; busy = 1.
  - If op == div and b == 0: go to FIN with the zero flag set.
  - Otherwise: go to RUN with cnt = 0.
- RUN:
  - One iteration per edge, cnt increments; at the edge where cnt == ITER-1, go to FIN.
  - Mult: unsigned shift-add on the magnitudes, 64-bit accumulator; the sign is applied in FIN.
  - Div: restoring division on the magnitudes. Each step shifts the remainder left, brings in the next dividend bit, trial-subtracts the divisor, and restores if negative.
- FIN (one edge):
  - Mult: {hi,lo} = (sign_a ^ sign_b) ? -product : product.
  - Div: lo = quotient negated if sign_a ^ sign_b; hi = remainder negated if sign_a. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Div by zero: hi/lo are NOT written; div_zero = 1.
  - At this edge: done = 1 for exactly one cycle, busy = 0, state = IDLE.
- Latency:
  - Normal mult/div: start sampled at E0, done high in the cycle after edge E(ITER+1), i.e. 33 cycles.
  - Div by zero: done high in the cycle after E1.
- Special cases and boundaries:
  - start while busy: ignored; operands are not re-latched; no second done.
  - start in the same cycle done is high: accepted, since the state is already IDLE.
  - Operand changes on a/b after E0: no effect.
  - 0x80000000 / -1: lo = 0x80000000, hi = 0 (wraps, no trap).
  - Magnitude of 0x80000000 is handled as unsigned 2^31, with no overflow.
- Outputs are registered; hi/lo hold their value between operations.

Decomposition:
- Package mult_div_pkg holds:
  - OP_MULT / OP_DIV encodings.
  - State encoding (IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2).
  - ITER and counter width (5 bits).
- Sub-module div_step: combinational restoring step.
  - Inputs: remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Instantiated once and reused every RUN cycle.
- The multiply datapath is kept inline in mult_div_unit.

Test Plan:
- Mult 7 × -3 (a = 0x00000007, b = 0xFFFFFFFD) → 33 cycles after start: done = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, div_zero = 0.
- Mult 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000; busy high for exactly 33 cycles.
- Div -7 / 2 (0xFFFFFFF9, 0x00000002) → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Then div 7 / -2 → lo = 0xFFFFFFFD, hi = 0x00000001.
- Div 5 / 0 with prior hi = 0x11, lo = 0x22 → done in the cycle after E1, div_zero = 1, hi/lo unchanged. The next accepted start clears div_zero.
- Div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0x00000000, no exception.
- Sequencing and reset:
  - Start mult, pulse start again at cycle 5 with new operands → ignored; the first result is delivered with a single done.
  - reset = 0 at cycle 10 of a second op → busy = 0, hi = lo = 0, no done.
  - start in the done cycle of a third op → accepted back-to-back.
